// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the single-precision multiplier
package fpu_pkg;

  localparam int          FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

endpackage

// File: rtl/fpu_round_norm.sv
// rtl/fpu_round_norm.sv - normalise a 48-bit mantissa product and round it to nearest-even
module fpu_round_norm
  import fpu_pkg::*;
(
  input  logic [47:0]        prod,
  input  logic signed [9:0]  exp,
  output logic [22:0]        frac,
  output logic [7:0]         exp_out,
  output logic               overflow,
  output logic               underflow
);

  logic [23:0]       mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [24:0]       sum;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_r;

  always_comb begin
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp + 10'sd1;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp;
    end
    round_up = guard & (sticky | mant[0]);
    sum      = {1'b0, mant} + {24'b0, round_up};
    // a rounding carry out of the hidden bit leaves an all-zero fraction
    if (sum[24]) begin
      frac  = sum[23:1];
      exp_r = exp_n + 10'sd1;
    end else begin
      frac  = sum[22:0];
      exp_r = exp_n;
    end
    exp_out   = exp_r[7:0];
    overflow  = (exp_r >= 10'sd255);
    underflow = (exp_r <= 10'sd0);
  end

endmodule

// File: rtl/fpu_mul_sequencer.sv
// rtl/fpu_mul_sequencer.sv - multi-cycle IEEE-754 single multiplier controller (FPU_MUL_SPECIAL_EN adds inf/NaN bypass)
module fpu_mul_sequencer
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int BIAS           = FP_BIAS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        busy
);

  localparam int         ITERS     = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  state_t            state_q, state_d;
  fp32_t             op_a_q, op_b_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [47:0]       acc_q, mcand_q, partial;
  logic [23:0]       mplier_q;
  logic [4:0]        iter_q;
  logic [22:0]       nfrac_q;
  logic [7:0]        nexp_q;
  logic              novf_q, nunf_q;
  logic [31:0]       result_q;
  logic              ovf_q, unf_q;

  logic              sign_u;
  logic              bypass;
  logic [31:0]       bypass_res;
  logic [22:0]       rn_frac;
  logic [7:0]        rn_exp;
  logic              rn_ovf, rn_unf;

  assign sign_u = op_a_q.sign ^ op_b_q.sign;

  // zero/subnormal operands flush; the special-value bypass takes priority when enabled
  always_comb begin
    bypass     = (op_a_q.exp == 8'd0) || (op_b_q.exp == 8'd0);
    bypass_res = {sign_u, 31'b0};
`ifdef FPU_MUL_SPECIAL_EN
    if (((op_a_q.exp == FP_EXP_MAX) && (op_a_q.frac != 23'd0)) ||
        ((op_b_q.exp == FP_EXP_MAX) && (op_b_q.frac != 23'd0)) ||
        ((op_a_q.exp == FP_EXP_MAX) && (op_b_q.exp == 8'd0)) ||
        ((op_b_q.exp == FP_EXP_MAX) && (op_a_q.exp == 8'd0))) begin
      bypass     = 1'b1;
      bypass_res = FP_QNAN;
    end else if ((op_a_q.exp == FP_EXP_MAX) || (op_b_q.exp == FP_EXP_MAX)) begin
      bypass     = 1'b1;
      bypass_res = {sign_u, FP_EXP_MAX, 23'b0};
    end
`endif
  end

  always_comb begin
    partial = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) partial = partial + (mcand_q << k);
    end
  end

  fpu_round_norm u_round_norm (
    .prod      (acc_q),
    .exp       (exp_q),
    .frac      (rn_frac),
    .exp_out   (rn_exp),
    .overflow  (rn_ovf),
    .underflow (rn_unf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = S_UNPACK;
      end
      S_UNPACK: state_d = bypass ? S_DONE : S_MULT;
      S_MULT:   if (iter_q == LAST_ITER) state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
      nfrac_q  <= '0;
      nexp_q   <= '0;
      novf_q   <= 1'b0;
      nunf_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_a_q <= a;
          op_b_q <= b;
          ovf_q  <= 1'b0;
          unf_q  <= 1'b0;
        end
        S_UNPACK: begin
          sign_q   <= sign_u;
          exp_q    <= 10'(op_a_q.exp) + 10'(op_b_q.exp) - 10'(BIAS);
          acc_q    <= '0;
          mcand_q  <= {24'b0, 1'b1, op_a_q.frac};
          mplier_q <= {1'b1, op_b_q.frac};
          iter_q   <= '0;
          if (bypass) result_q <= bypass_res;
        end
        S_MULT: begin
          acc_q    <= acc_q + partial;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          iter_q   <= (iter_q == LAST_ITER) ? 5'd0 : iter_q + 5'd1;
        end
        S_NORM: begin
          nfrac_q <= rn_frac;
          nexp_q  <= rn_exp;
          novf_q  <= rn_ovf;
          nunf_q  <= rn_unf;
        end
        S_ROUND: begin
          ovf_q <= novf_q;
          unf_q <= nunf_q & ~novf_q;
          if (novf_q)      result_q <= {sign_q, FP_EXP_MAX, 23'b0};
          else if (nunf_q) result_q <= {sign_q, 31'b0};
          else             result_q <= {sign_q, nexp_q, nfrac_q};
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fpu_mul_sequencer.sv
// tb/tb_fpu_mul_sequencer.sv - directed self-checking bench for fpu_mul_sequencer
module tb_fpu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fpu_mul_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .busy      (busy)
  );

  // Drives one operation; leaves the result pending when hold is set.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input bit hold,
                        output logic [31:0] r, output logic o, output logic u, output int lat);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    r = result; o = overflow; u = underflow;
    if (!hold) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
    n_total++; if (underflow !== 1'b0) $display("FAIL reset_underflow got %b want 0", underflow); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [31:0] r; logic o, u; int lat;
    run_op(32'h3FC00000, 32'h40000000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h40400000) $display("FAIL basic_result got %h want 40400000", r); else n_pass++;
    n_total++; if (lat !== 27) $display("FAIL basic_latency got %0d want 27", lat); else n_pass++;
    n_total++; if ({o, u} !== 2'b00) $display("FAIL basic_flags got %b want 00", {o, u}); else n_pass++;
    run_op(32'hC0000000, 32'h3FC00000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'hC0400000) $display("FAIL negative_result got %h want C0400000", r); else n_pass++;
  endtask

  task automatic test_rne;
    logic [31:0] r; logic o, u; int lat;
    run_op(32'h3F800001, 32'h3F800001, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h3F800002) $display("FAIL rne_sticky got %h want 3F800002", r); else n_pass++;
    run_op(32'h3F800001, 32'h3FC00000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h3FC00002) $display("FAIL rne_tie_odd got %h want 3FC00002", r); else n_pass++;
    run_op(32'h3F800003, 32'h3FC00000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h3FC00004) $display("FAIL rne_tie_even got %h want 3FC00004", r); else n_pass++;
  endtask

  task automatic test_range;
    logic [31:0] r; logic o, u; int lat;
    run_op(32'h7F000000, 32'h7F000000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h7F800000) $display("FAIL ovf_result got %h want 7F800000", r); else n_pass++;
    n_total++; if ({o, u} !== 2'b10) $display("FAIL ovf_flags got %b want 10", {o, u}); else n_pass++;
    run_op(32'h00800000, 32'h00800000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h00000000) $display("FAIL unf_result got %h want 00000000", r); else n_pass++;
    n_total++; if ({o, u} !== 2'b01) $display("FAIL unf_flags got %b want 01", {o, u}); else n_pass++;
    run_op(32'h80000000, 32'h3F800000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h80000000) $display("FAIL flush_result got %h want 80000000", r); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL flush_latency got %0d want 1", lat); else n_pass++;
    n_total++; if ({o, u} !== 2'b00) $display("FAIL flush_flags got %b want 00", {o, u}); else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [31:0] r; logic o, u; int lat;
    run_op(32'h7F000000, 32'h7F000000, 1'b1, r, o, u, lat);
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (result !== 32'h7F800000 || overflow !== 1'b1 || underflow !== 1'b0 ||
          in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
        $display("FAIL backpressure_hold cycle %0d got res=%h ovf=%b unf=%b rdy=%b busy=%b vld=%b want 7F800000 1 0 0 1 1",
                 i, result, overflow, underflow, in_ready, busy, out_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL backpressure_release got rdy=%b busy=%b vld=%b want 1 0 0", in_ready, busy, out_valid);
    else n_pass++;
  endtask

  task automatic test_abort;
    logic [31:0] r; logic o, u; int lat;
    a = 32'h40000000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
    end
    n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
        overflow !== 1'b0 || underflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_reset got rdy=%b vld=%b res=%h ovf=%b unf=%b busy=%b want 1 0 00000000 0 0 0",
               in_ready, out_valid, result, overflow, underflow, busy);
    else n_pass++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h40000000, 32'h40000000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h40800000) $display("FAIL post_abort_result got %h want 40800000", r); else n_pass++;
    n_total++; if (lat !== 27) $display("FAIL post_abort_latency got %0d want 27", lat); else n_pass++;
  endtask

`ifdef FPU_MUL_SPECIAL_EN
  task automatic test_special;
    logic [31:0] r; logic o, u; int lat;
    run_op(32'h7FC00000, 32'h3F800000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h7FC00000 || {o, u} !== 2'b00 || lat !== 1)
      $display("FAIL special_nan got %h %b lat %0d want 7FC00000 00 1", r, {o, u}, lat); else n_pass++;
    run_op(32'h7F800000, 32'h00000000, 1'b0, r, o, u, lat);
    n_total++; if (r !== 32'h7FC00000 || {o, u} !== 2'b00 || lat !== 1)
      $display("FAIL special_inf_zero got %h %b lat %0d want 7FC00000 00 1", r, {o, u}, lat); else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_rne;
    test_range;
    test_backpressure;
    test_abort;
`ifdef FPU_MUL_SPECIAL_EN
    test_special;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
